// File: rtl/sar_search_pkg.sv
// Shared definitions for the successive-approximation search controller:
// FSM state encoding and one-hot comparator flag codes ({lt, gt, eq}).
package sar_search_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } searchStateT;

  localparam logic [2:0] FLAG_EQ = 3'b001;
  localparam logic [2:0] FLAG_GT = 3'b010;
  localparam logic [2:0] FLAG_LT = 3'b100;

endpackage

// File: rtl/sar_search_step.sv
// Combinational narrowing step: from the current bounds, probe and comparator
// flags it produces the next bounds and decides whether the search is over.
module sar_search_step
  import sar_search_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] probe,
  input  logic [2:0]       flags,
  output logic [WIDTH-1:0] nextLo,
  output logic [WIDTH-1:0] nextHi,
  output logic             terminate,
  output logic             hit,
  output logic             illegal
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;

  // Edge probes terminate before the +1/-1 so the bounds can never wrap.
  always_comb begin
    nextLo    = lo;
    nextHi    = hi;
    terminate = 1'b0;
    hit       = 1'b0;
    illegal   = 1'b0;
    case (flags)
      FLAG_EQ: begin
        terminate = 1'b1;
        hit       = 1'b1;
      end
      FLAG_GT: begin
        if (probe == MAX_VAL) begin
          terminate = 1'b1;
        end else begin
          nextLo = probe + WIDTH'(1);
          if (nextLo > hi) terminate = 1'b1;
        end
      end
      FLAG_LT: begin
        if (probe == '0) begin
          terminate = 1'b1;
        end else begin
          nextHi = probe - WIDTH'(1);
          if (lo > nextHi) terminate = 1'b1;
        end
      end
      default: begin
        illegal   = 1'b1;
        terminate = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/sar_search_ctrl.sv
// Binary-search controller driving an external magnitude comparator; probe and
// probe_valid decode from registered state, every other output is registered.
module sar_search_ctrl
  import sar_search_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] probe,
  output logic             probe_valid,
  input  logic             cmp_valid,
  input  logic             cmp_eq,
  input  logic             cmp_gt,
  input  logic             cmp_lt,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             err,
  output logic [WIDTH-1:0] result
);

  searchStateT      state;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic [WIDTH:0]   midSum;
  logic [WIDTH-1:0] nextLo;
  logic [WIDTH-1:0] nextHi;
  logic             terminate;
  logic             hit;
  logic             illegal;

  // One extra bit keeps lo+hi from overflowing before the halving.
  assign midSum      = {1'b0, lo} + {1'b0, hi};
  assign probe       = (state == SEARCH) ? midSum[WIDTH:1] : '0;
  assign probe_valid = (state == SEARCH);

  sar_search_step #(
    .WIDTH(WIDTH)
  ) stepInst (
    .lo       (lo),
    .hi       (hi),
    .probe    (probe),
    .flags    ({cmp_lt, cmp_gt, cmp_eq}),
    .nextLo   (nextLo),
    .nextHi   (nextHi),
    .terminate(terminate),
    .hit      (hit),
    .illegal  (illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      lo     <= '0;
      hi     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      found  <= 1'b0;
      err    <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            lo     <= '0;
            hi     <= '1;
            found  <= 1'b0;
            err    <= 1'b0;
            result <= '0;
            busy   <= 1'b1;
            state  <= SEARCH;
          end
        end
        SEARCH: begin
          if (cmp_valid) begin
            if (terminate) begin
              state <= DONE;
              done  <= 1'b1;
              found <= hit;
              err   <= illegal;
              if (hit) result <= probe;
            end else begin
              lo <= nextLo;
              hi <= nextHi;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sar_search_ctrl.md
SAR_SEARCH_CTRL -- requirements
Module: sar_search_ctrl

Interface
REQ-001 Parameter: WIDTH, default 4, bit width of the searched value and the probe (WIDTH >= 2).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle request to begin a search; sampled in IDLE only.
REQ-005 probe  output  WIDTH  candidate value driven to the external magnitude comparator (comparator B operand).
REQ-006 probe_valid  output  1  high while probe is valid and a comparator response is awaited.
REQ-007 cmp_valid  input  1  comparator response valid for the current probe.
REQ-008 cmp_eq / cmp_gt / cmp_lt  input  1 each  comparator flags: target equal to, greater than, or less than probe.
REQ-009 busy  output  1  high from search acceptance until done.
REQ-010 done  output  1  one-cycle pulse at search completion.
REQ-011 found  output  1  result is an exact match; valid from done until the next accepted start.
REQ-012 err  output  1  illegal flag combination seen; valid from done until the next accepted start.
REQ-013 result  output  WIDTH  matching value when found=1, else 0; held like found.

Function
REQ-014 FSM states: IDLE, SEARCH, DONE; DONE lasts exactly one cycle and returns to IDLE.
REQ-015 IDLE + start=1: lo<=0, hi<=2^WIDTH-1; clear found, err, result; go to SEARCH; busy=1 next cycle.
REQ-016 start is ignored in SEARCH and DONE; no queuing.
REQ-017 In SEARCH: probe = floor((lo+hi)/2), computed at WIDTH+1 bits with no overflow; probe_valid=1.
REQ-018 SEARCH + cmp_valid=0: hold lo, hi and probe; unbounded stall allowed.
REQ-019 SEARCH + cmp_valid=1 with exactly one flag set: eq -> found=1, result=probe, go DONE; gt -> lo=probe+1; lt -> hi=probe-1.
REQ-020 gt with probe=2^WIDTH-1, or lt with probe=0: go DONE with found=0 and no wrap-around of lo/hi.
REQ-021 After a gt/lt update, lo>hi: go DONE with found=0.
REQ-022 cmp_valid=1 with zero or more than one flag set: err=1, found=0, go DONE.
REQ-023 Search completes within WIDTH+1 accepted responses.
REQ-024 done=1 only in DONE; busy=1 in SEARCH and DONE; probe_valid=0 outside SEARCH; probe=0 outside SEARCH.

Reset
REQ-025 rst_n low at any time, including mid-search: state=IDLE; lo, hi, probe, result=0; probe_valid, busy, done, found, err=0.
REQ-026 The first start after rst_n deasserts is accepted normally; no partial search survives reset.

Structure
REQ-027 A shared package sar_search_pkg holds the FSM state enum and the comparator-flag one-hot encoding constants.
REQ-028 One sub-module, sar_search_step, holds the combinational next-lo/next-hi/terminate logic and the REQ-020/REQ-021 boundary checks.
REQ-029 FSM and registers are in sar_search_ctrl; all outputs are registered except probe and probe_valid, which decode from registered state.

Verification (WIDTH=4, comparator model with zero-wait response unless stated)
REQ-030 Target 11 -> probes 7(gt), 11(eq); done on the cycle after the second response; found=1, result=11.
REQ-031 Target 0 -> probes 7, 3, 1, 0 (lt, lt, lt, eq); found=1, result=0, no hi underflow.
REQ-032 Model always answers gt -> probes 7, 11, 13, 14, 15; then found=0, err=0, result=0.
REQ-033 First response has cmp_eq=1 and cmp_gt=1 -> err=1, found=0, one done pulse; the next start clears err.
REQ-034 Target 5 with cmp_valid held low for 3 cycles per probe -> probe stays stable during each stall; found=1, result=5.
REQ-035 rst_n asserted after the second probe of a search -> all outputs are 0 immediately; start after release yields a correct fresh search; start pulsed while busy is ignored.
